arashi_rr_arbiter: RTL and testbench

Parametrised round-robin thread arbiter that picks which thread's pending request goes to the shared cache read port. It supports any power-of-two thread count and a per-thread enable mask. Grants use a valid/ready handshake with the cache and stay stable under backpressure. A thread may hold the port for a bounded burst of consecutive grants before priority rotates. It sits between the per-thread request logic and the cache read port.

---
 rtl/arashi_arb_pkg.sv | 27 ++
 rtl/arashi_rr_arbiter_if.sv | 44 ++++
 rtl/arashi_rr_pick.sv | 47 ++++
 rtl/arashi_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_arashi_rr_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/arashi_arb_pkg.sv
// rtl/arashi_arb_pkg.sv - shared types and helpers for the round-robin thread arbiter
//
// Purpose: arbiter FSM state type, statistics counter width and small
// sizing helpers used by the arbiter, its interface and the pick logic.
// Ports: none (package).

package arashi_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  // Width of each per-thread accepted-grant counter.
  localparam int STAT_W = 16;

  // Number of threads for a given index width.
  function automatic int rr_thread_num(input int width);
    return 1 << width;
  endfunction

  // Index width needed to name one of n threads.
  function automatic int rr_pick_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arashi_rr_arbiter_if.sv
// rtl/arashi_rr_arbiter_if.sv - request/grant bundle between thread logic, arbiter and cache
//
// Purpose: groups the per-thread request vectors and the grant handshake.
// Signals:
//   avail  [THREAD_NUM]        per-thread request pending
//   mask   [THREAD_NUM]        per-thread enable
//   toread [THREAD_NUM_WIDTH]  granted thread index
//   rcache                     grant valid to cache
//   rready                     cache accepts grant
// Modports:
//   master - arbiter side (drives toread/rcache)
//   slave  - requester/cache side (drives avail/mask/rready)

interface arashi_rr_arbiter_if
  import arashi_arb_pkg::*;
#(
  parameter int THREAD_NUM_WIDTH = 2
);

  localparam int THREAD_NUM = rr_thread_num(THREAD_NUM_WIDTH);

  logic [THREAD_NUM-1:0]       avail;
  logic [THREAD_NUM-1:0]       mask;
  logic [THREAD_NUM_WIDTH-1:0] toread;
  logic                        rcache;
  logic                        rready;

  modport master (
    input  avail,
    input  mask,
    input  rready,
    output toread,
    output rcache
  );

  modport slave (
    output avail,
    output mask,
    output rready,
    input  toread,
    input  rcache
  );

endinterface

// File: rtl/arashi_rr_pick.sv
// rtl/arashi_rr_pick.sv - combinational rotate-and-priority-encode thread picker
//
// Purpose: chooses the first eligible thread at or after i_ptr, wrapping.
// Ports:
//   i_eligible   [THREAD_NUM]        eligible threads (avail & mask)
//   i_ptr        [THREAD_NUM_WIDTH]  highest-priority thread index
//   o_pick       [THREAD_NUM_WIDTH]  chosen thread index
//   o_pick_valid                     at least one thread is eligible

module arashi_rr_pick
  import arashi_arb_pkg::*;
#(
  parameter int THREAD_NUM_WIDTH = 2
) (
  input  logic [rr_thread_num(THREAD_NUM_WIDTH)-1:0] i_eligible,
  input  logic [THREAD_NUM_WIDTH-1:0]                i_ptr,
  output logic [THREAD_NUM_WIDTH-1:0]                o_pick,
  output logic                                       o_pick_valid
);

  localparam int THREAD_NUM = rr_thread_num(THREAD_NUM_WIDTH);
  localparam int IDX_W      = rr_pick_width(THREAD_NUM);

  logic [THREAD_NUM-1:0] w_rot;
  logic [IDX_W-1:0]      w_idx;

  always_comb begin
    // Rotate right by i_ptr: thread ptr lands in bit 0. The index sum is
    // IDX_W wide, so it wraps modulo THREAD_NUM for free.
    w_rot = '0;
    for (int i = 0; i < THREAD_NUM; i++) begin
      w_rot[i] = i_eligible[IDX_W'(i) + i_ptr];
    end

    // Lowest set bit wins: scan downward so the last hit is the lowest.
    w_idx = '0;
    for (int i = THREAD_NUM - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_idx = IDX_W'(i);
      end
    end

    o_pick       = w_idx + i_ptr;
    o_pick_valid = |i_eligible;
  end

endmodule

// File: rtl/arashi_rr_arbiter.sv
// rtl/arashi_rr_arbiter.sv - round-robin thread arbiter for the shared cache read port
//
// Purpose: grants one eligible thread at a time to the cache with a
// valid/ready handshake, allowing up to BURST_MAX consecutive accepted
// grants to one thread before priority rotates past it.
// Ports:
//   clk          clock
//   rst          synchronous reset, active-high
//   bus          arashi_rr_arbiter_if.master (avail, mask, rready in;
//                toread, rcache out, both registered)
//   stat_clr     clear grant counters        (ARASHI_ARB_STATS_EN only)
//   stat_grants  16-bit counter per thread,  (ARASHI_ARB_STATS_EN only)
//                thread i at [16i+15:16i]
// Build option: define ARASHI_ARB_STATS_EN to add the per-thread counters.

module arashi_rr_arbiter
  import arashi_arb_pkg::*;
#(
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int BURST_MAX        = 1,
  parameter int BURST_WIDTH      = 4
) (
  input  logic clk,
  input  logic rst,
  arashi_rr_arbiter_if.master bus
`ifdef ARASHI_ARB_STATS_EN
  ,
  input  logic                                              stat_clr,
  output logic [rr_thread_num(THREAD_NUM_WIDTH)*STAT_W-1:0] stat_grants
`endif
);

  localparam int THREAD_NUM = rr_thread_num(THREAD_NUM_WIDTH);

  arb_state_t                  r_state;
  logic                        r_rcache;
  logic [THREAD_NUM_WIDTH-1:0] r_toread;
  logic [THREAD_NUM_WIDTH-1:0] r_ptr;
  logic [BURST_WIDTH-1:0]      r_burst;

  logic [THREAD_NUM-1:0]       w_elig;
  logic                        w_accept;
  logic                        w_rotate;
  logic [THREAD_NUM_WIDTH-1:0] w_ptr_upd;
  logic [BURST_WIDTH-1:0]      w_burst_upd;
  logic [THREAD_NUM_WIDTH-1:0] w_pick_ptr;
  logic [THREAD_NUM_WIDTH-1:0] w_pick;
  logic                        w_pick_valid;

  assign w_elig   = bus.avail & bus.mask;
  assign w_accept = (r_state == ARB_GRANT) && bus.rready;

  // Leave the current thread when its burst is used up or it has dropped
  // out of eligibility; otherwise keep it at top priority.
  assign w_rotate    = (r_burst == BURST_WIDTH'(BURST_MAX - 1)) || !w_elig[r_toread];
  assign w_ptr_upd   = w_rotate ? (r_toread + THREAD_NUM_WIDTH'(1)) : r_toread;
  assign w_burst_upd = w_rotate ? '0 : (r_burst + BURST_WIDTH'(1));

  // On accept the follow-on grant is picked against the pointer being
  // written this edge, which is what makes back-to-back grants bubble-free.
  assign w_pick_ptr = (r_state == ARB_GRANT) ? w_ptr_upd : r_ptr;

  arashi_rr_pick #(
    .THREAD_NUM_WIDTH(THREAD_NUM_WIDTH)
  ) u_pick (
    .i_eligible  (w_elig),
    .i_ptr       (w_pick_ptr),
    .o_pick      (w_pick),
    .o_pick_valid(w_pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_rcache <= 1'b0;
      r_toread <= '0;
      r_ptr    <= '0;
      r_burst  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_state  <= ARB_GRANT;
            r_rcache <= 1'b1;
            r_toread <= w_pick;
          end
        end
        ARB_GRANT: begin
          // Without rready the grant is frozen regardless of avail/mask.
          if (bus.rready) begin
            r_ptr   <= w_ptr_upd;
            r_burst <= w_burst_upd;
            if (w_pick_valid) begin
              r_toread <= w_pick;
            end else begin
              r_state  <= ARB_IDLE;
              r_rcache <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= ARB_IDLE;
          r_rcache <= 1'b0;
        end
      endcase
    end
  end

  assign bus.toread = r_toread;
  assign bus.rcache = r_rcache;

`ifdef ARASHI_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat [THREAD_NUM];

  // Clear has priority over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < THREAD_NUM; i++) begin
        r_stat[i] <= '0;
      end
    end else if (w_accept && (r_stat[r_toread] != {STAT_W{1'b1}})) begin
      r_stat[r_toread] <= r_stat[r_toread] + STAT_W'(1);
    end
  end

  for (genvar g = 0; g < THREAD_NUM; g++) begin : g_stat
    assign stat_grants[g*STAT_W +: STAT_W] = r_stat[g];
  end
`endif

endmodule

// File: tb/tb_arashi_rr_arbiter.sv
// tb/tb_arashi_rr_arbiter.sv - directed self-checking bench for arashi_rr_arbiter
//
// Purpose: drives three arbiter instances (4 threads pure round-robin,
// 4 threads with BURST_MAX=2, 2 threads) with directed vectors and checks
// grants against hand-computed sequences.
// Ports: none (top-level bench). Honours ARASHI_ARB_STATS_EN.

module tb_arashi_rr_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  arashi_rr_arbiter_if #(.THREAD_NUM_WIDTH(2)) if_rr ();
  arashi_rr_arbiter_if #(.THREAD_NUM_WIDTH(2)) if_bu ();
  arashi_rr_arbiter_if #(.THREAD_NUM_WIDTH(1)) if_w1 ();

`ifdef ARASHI_ARB_STATS_EN
  logic        stat_clr;
  logic [63:0] sg_rr;
  logic [63:0] sg_bu;
  logic [31:0] sg_w1;
`endif

  arashi_rr_arbiter #(.THREAD_NUM_WIDTH(2), .BURST_MAX(1), .BURST_WIDTH(4)) u_rr (
    .clk(clk),
    .rst(rst),
    .bus(if_rr.master)
`ifdef ARASHI_ARB_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat_grants(sg_rr)
`endif
  );

  arashi_rr_arbiter #(.THREAD_NUM_WIDTH(2), .BURST_MAX(2), .BURST_WIDTH(4)) u_bu (
    .clk(clk),
    .rst(rst),
    .bus(if_bu.master)
`ifdef ARASHI_ARB_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat_grants(sg_bu)
`endif
  );

  arashi_rr_arbiter #(.THREAD_NUM_WIDTH(1), .BURST_MAX(1), .BURST_WIDTH(4)) u_w1 (
    .clk(clk),
    .rst(rst),
    .bus(if_w1.master)
`ifdef ARASHI_ARB_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat_grants(sg_w1)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_rr [5] = '{1, 2, 3, 0, 1};
  int exp_mk [4] = '{1, 3, 1, 3};
  int exp_bu [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int exp_w1 [4] = '{0, 1, 0, 1};

  initial begin
    rst          = 1'b1;
    if_rr.avail  = 4'b1111;
    if_rr.mask   = 4'b1111;
    if_rr.rready = 1'b1;
    if_bu.avail  = 4'b0000;
    if_bu.mask   = 4'b1111;
    if_bu.rready = 1'b1;
    if_w1.avail  = 2'b00;
    if_w1.mask   = 2'b11;
    if_w1.rready = 1'b1;
`ifdef ARASHI_ARB_STATS_EN
    stat_clr     = 1'b0;
`endif

    // Reset
    tick(2);
    check("rst_rcache", 32'(if_rr.rcache), 0);
    check("rst_toread", 32'(if_rr.toread), 0);
    rst = 1'b0;
    tick(1);
    check("first_rcache", 32'(if_rr.rcache), 1);
    check("first_toread", 32'(if_rr.toread), 0);

    // Pure round-robin, everyone requesting
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check($sformatf("rr_toread_%0d", i), 32'(if_rr.toread), 32'(exp_rr[i]));
      check($sformatf("rr_rcache_%0d", i), 32'(if_rr.rcache), 1);
    end

    // Backpressure at thread 2 while avail shrinks to thread 0 only
    tick(1);
    check("bp_grant2", 32'(if_rr.toread), 2);
    if_rr.rready = 1'b0;
    if_rr.avail  = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("bp_hold_toread_%0d", i), 32'(if_rr.toread), 2);
      check($sformatf("bp_hold_rcache_%0d", i), 32'(if_rr.rcache), 1);
    end
    if_rr.rready = 1'b1;
    tick(1);
    check("bp_next_toread", 32'(if_rr.toread), 0);
    check("bp_next_rcache", 32'(if_rr.rcache), 1);

    // Requests vanish: grant drops one cycle after the last accept
    if_rr.avail = 4'b0000;
    tick(1);
    check("empty_drop", 32'(if_rr.rcache), 0);
    tick(1);
    check("empty_idle", 32'(if_rr.rcache), 0);

    // Fully masked: never granted
    if_rr.avail = 4'b1111;
    if_rr.mask  = 4'b0000;
    tick(1);
    check("mask0_a", 32'(if_rr.rcache), 0);
    tick(1);
    check("mask0_b", 32'(if_rr.rcache), 0);

    // Partial mask with wrap
    if_rr.mask = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check($sformatf("mask_toread_%0d", i), 32'(if_rr.toread), 32'(exp_mk[i]));
    end
    if_rr.avail = 4'b0000;
    tick(1);
    check("mask_drop", 32'(if_rr.rcache), 0);

    // Burst of two per thread
    if_bu.avail = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      check($sformatf("bu_toread_%0d", i), 32'(if_bu.toread), 32'(exp_bu[i]));
    end
    tick(1);
    check("bu_second0", 32'(if_bu.toread), 0);
    tick(1);
    check("bu_first1", 32'(if_bu.toread), 1);
    if_bu.avail = 4'b1101;
    tick(1);
    check("bu_drop1", 32'(if_bu.toread), 2);
    tick(1);
    check("bu_second2", 32'(if_bu.toread), 2);
    if_bu.avail = 4'b0000;
    tick(1);
    check("bu_drop", 32'(if_bu.rcache), 0);

    // Two threads alternate
    if_w1.avail = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check($sformatf("w1_toread_%0d", i), 32'(if_w1.toread), 32'(exp_w1[i]));
    end
    if_w1.avail = 2'b00;
    tick(1);
    check("w1_drop", 32'(if_w1.rcache), 0);

`ifdef ARASHI_ARB_STATS_EN
    if_rr.mask   = 4'b1111;
    if_rr.rready = 1'b0;
    stat_clr     = 1'b1;
    tick(1);
    stat_clr     = 1'b0;
    check("stat_clr0", 32'(sg_rr[31:16]), 0);
    if_rr.avail = 4'b0010;
    tick(1);
    check("stat_grant1", 32'(if_rr.toread), 1);
    if_rr.rready = 1'b1;
    tick(5);
    check("stat_five", 32'(sg_rr[31:16]), 5);
    check("stat_other", 32'(sg_rr[15:0]), 0);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    check("stat_clr_accept", 32'(sg_rr[31:16]), 0);
    tick(65540);
    check("stat_sat", 32'(sg_rr[31:16]), 32'hFFFF);
    if_rr.rready = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
